// File: rtl/soc_ram_arb_pkg.sv
// rtl/soc_ram_arb_pkg.sv - shared types and constants for the SoC RAM arbiter
package soc_ram_arb_pkg;

   typedef enum logic {
      PORT_IFETCH = 1'b0,
      PORT_DATA   = 1'b1
   } port_t;

   localparam int RAM_RD_LATENCY = 1;

endpackage

// File: rtl/soc_sat_counter.sv
// rtl/soc_sat_counter.sv - saturating event counter with synchronous clear
module soc_sat_counter #(
   parameter int width = 32
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             inc,
   input  logic             clr,
   output logic [width-1:0] cnt
);

   // clear wins over increment; the count sticks at all-ones
   always_ff @(posedge i_clk) begin
      if (i_rst || clr) begin
         cnt <= '0;
      end else if (inc && (cnt != {width{1'b1}})) begin
         cnt <= cnt + width'(1);
      end
   end

endmodule

// File: rtl/soc_ram_arbiter.sv
// rtl/soc_ram_arbiter.sv - round-robin ifetch/data arbiter for one 1-cycle-latency RAM; stats via SOC_RAM_ARB_STATS_EN
module soc_ram_arbiter
   import soc_ram_arb_pkg::*;
#(
   parameter int p_cnt_width = 32
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [31:2] i_req0_addr,
   input  logic        i_req0_rd_en,
   output logic        o_req0_ack,
   output logic        o_req0_rvalid,
   input  logic [31:2] i_req1_addr,
   input  logic [3:0]  i_req1_be,
   input  logic        i_req1_wr_en,
   input  logic [31:0] i_req1_wr_data,
   input  logic        i_req1_rd_en,
   output logic        o_req1_ack,
   output logic        o_req1_rvalid,
   output logic [31:0] o_rd_data,
   output logic [31:2] o_ram_addr,
   output logic [3:0]  o_ram_be,
   output logic        o_ram_wr_en,
   output logic [31:0] o_ram_wr_data,
   output logic        o_ram_rd_en,
   input  logic [31:0] i_ram_rd_data
`ifdef SOC_RAM_ARB_STATS_EN
   ,
   input  logic                   i_stats_clr,
   output logic [p_cnt_width-1:0] o_cnt_grant0,
   output logic [p_cnt_width-1:0] o_cnt_grant1,
   output logic [p_cnt_width-1:0] o_cnt_conflict
`endif
);

   if ((p_cnt_width < 1) || (p_cnt_width > 32) || (RAM_RD_LATENCY != 1)) begin : g_bad_cfg
      $error("soc_ram_arbiter: unsupported configuration");
   end

   logic  req0;
   logic  req1;
   logic  grant0;
   logic  grant1;
   port_t last_grant;
   logic  rd_owner_vld;
   port_t rd_owner;

   assign req0 = i_req0_rd_en;
   assign req1 = i_req1_rd_en | i_req1_wr_en;

   // on a conflict the port that did not win last time goes first
   assign grant0 = ~i_rst & req0 & (~req1 | (last_grant == PORT_DATA));
   assign grant1 = ~i_rst & req1 & (~req0 | (last_grant == PORT_IFETCH));

   assign o_req0_ack = grant0;
   assign o_req1_ack = grant1;

   assign o_ram_addr    = grant1 ? i_req1_addr : i_req0_addr;
   assign o_ram_be      = grant1 ? i_req1_be : 4'b0000;
   assign o_ram_wr_en   = grant1 & i_req1_wr_en;
   assign o_ram_wr_data = grant1 ? i_req1_wr_data : 32'h0;
   // a combined read+write from port 1 is treated as a write only
   assign o_ram_rd_en   = grant0 | (grant1 & i_req1_rd_en & ~i_req1_wr_en);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         last_grant   <= PORT_DATA;
         rd_owner_vld <= 1'b0;
         rd_owner     <= PORT_IFETCH;
      end else begin
         if (grant0) begin
            last_grant <= PORT_IFETCH;
         end else if (grant1) begin
            last_grant <= PORT_DATA;
         end
         rd_owner_vld <= o_ram_rd_en;
         rd_owner     <= grant1 ? PORT_DATA : PORT_IFETCH;
      end
   end

   // owner is registered alongside the RAM's own read register, so data and strobe line up
   assign o_req0_rvalid = ~i_rst & rd_owner_vld & (rd_owner == PORT_IFETCH);
   assign o_req1_rvalid = ~i_rst & rd_owner_vld & (rd_owner == PORT_DATA);
   assign o_rd_data     = i_ram_rd_data;

`ifdef SOC_RAM_ARB_STATS_EN
   soc_sat_counter #(.width(p_cnt_width)) u_cnt_grant0 (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .inc   (grant0),
      .clr   (i_stats_clr),
      .cnt   (o_cnt_grant0)
   );

   soc_sat_counter #(.width(p_cnt_width)) u_cnt_grant1 (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .inc   (grant1),
      .clr   (i_stats_clr),
      .cnt   (o_cnt_grant1)
   );

   soc_sat_counter #(.width(p_cnt_width)) u_cnt_conflict (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .inc   (req0 & req1),
      .clr   (i_stats_clr),
      .cnt   (o_cnt_conflict)
   );
`endif

endmodule
